// File: rtl/multi_transfer_sequencer.sv
// Multi-register LM/SM/LA/SA transfer sequencer for the MEM stage.
// Optional SEQ_ZERO_SKIP_EN: jump straight to the next set mask bit (no bubble cycles).
module multi_transfer_sequencer #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 7,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  input  logic [3:0]        opcode,
  input  logic [NREG-1:0]   imm_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [IDX_W-1:0]  reg_idx,
  output logic              rf_wr_en,
  output logic              stall_o,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for a multi-op; stall only in the start cycle
  // RUN   | stepping k over registers, one memory beat per active k
  // FIN   | one-cycle done pulse, pipeline released, no new start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  k, k_nxt, l, l_nxt;
  logic [3:0]        op_q, op_nxt;
  logic [NREG-1:0]   mask_q, mask_nxt, mask_rev;
  logic [ADDR_W-1:0] base_q, base_nxt;

  logic             multi_op, is_all, is_load, k_active, strobe, k_last;
  logic [IDX_W-1:0] off;

  assign multi_op = start_valid & (opcode[3:2] == 2'b11);
  assign is_all   = op_q[1];
  assign is_load  = ~op_q[0];

  // mask bit (NREG-1-k) selects register k; reverse once so k indexes directly
  always_comb begin
    mask_rev = '0;
    for (int j = 0; j < NREG; j++) mask_rev[j] = mask_q[NREG-1-j];
  end

  assign k_active = is_all | mask_rev[k];
  assign strobe   = (state == S_RUN) & k_active;

`ifdef SEQ_ZERO_SKIP_EN
  logic [NREG-1:0]  imm_rev;
  logic [IDX_W-1:0] nxt_set, first_set;
  logic             nxt_found;

  always_comb begin
    imm_rev   = '0;
    nxt_set   = '0;
    nxt_found = 1'b0;
    first_set = '0;
    for (int j = 0; j < NREG; j++) imm_rev[j] = imm_mask[NREG-1-j];
    // scan downward so the lowest qualifying index wins
    for (int j = NREG-1; j >= 0; j--) begin
      if (j > int'(k) && mask_rev[j]) begin
        nxt_found = 1'b1;
        nxt_set   = IDX_W'(j);
      end
      if (imm_rev[j]) first_set = IDX_W'(j);
    end
  end

  assign k_last = is_all ? (k == IDX_W'(NREG-1)) : ~nxt_found;
`else
  assign k_last = (k == IDX_W'(NREG-1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      k      <= '0;
      l      <= '0;
      op_q   <= '0;
      mask_q <= '0;
      base_q <= '0;
    end else begin
      state  <= state_nxt;
      k      <= k_nxt;
      l      <= l_nxt;
      op_q   <= op_nxt;
      mask_q <= mask_nxt;
      base_q <= base_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    l_nxt     = l;
    op_nxt    = op_q;
    mask_nxt  = mask_q;
    base_nxt  = base_q;
    case (state)
      S_IDLE: begin
        if (multi_op) begin
          op_nxt   = opcode;
          mask_nxt = imm_mask;
          base_nxt = base_addr;
          k_nxt    = '0;
          l_nxt    = '0;
`ifdef SEQ_ZERO_SKIP_EN
          if (!opcode[1]) k_nxt = first_set;
`endif
          if (!opcode[1] && (imm_mask == '0)) state_nxt = S_FIN;
          else                                 state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!k_active || mem_ready) begin
          if (k_active && !is_all) l_nxt = l + 1'b1;
          if (k_last) begin
            state_nxt = S_FIN;
          end else begin
`ifdef SEQ_ZERO_SKIP_EN
            k_nxt = is_all ? k + 1'b1 : nxt_set;
`else
            k_nxt = k + 1'b1;
`endif
          end
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign off = is_all ? k : l;

  always_comb begin
    mem_addr  = '0;
    reg_idx   = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    rf_wr_en  = 1'b0;
    stall_o   = 1'b0;
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    case (state)
      S_IDLE: stall_o = multi_op;
      S_RUN: begin
        stall_o = 1'b1;
        if (strobe) begin
          mem_addr  = base_q + {{(ADDR_W-IDX_W){1'b0}}, off};
          reg_idx   = k;
          mem_rd_en = is_load;
          mem_wr_en = ~is_load;
          rf_wr_en  = is_load & mem_ready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_transfer_sequencer.sv
// Scoreboard bench for multi_transfer_sequencer: expected beats queued by stimulus, checked by a monitor.
module tb_multi_transfer_sequencer;

  logic        clk, rst_n, start_valid, mem_ready;
  logic [3:0]  opcode;
  logic [6:0]  imm_mask;
  logic [15:0] base_addr, mem_addr;
  logic        mem_rd_en, mem_wr_en, rf_wr_en, stall_o, busy, done;
  logic [2:0]  reg_idx;

  multi_transfer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .opcode(opcode),
    .imm_mask(imm_mask), .base_addr(base_addr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .reg_idx(reg_idx), .rf_wr_en(rf_wr_en), .stall_o(stall_o),
    .busy(busy), .done(done)
  );

  typedef struct { logic [15:0] addr; logic [2:0] idx; logic wr; } beat_t;
  beat_t exp_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: every strobed cycle is compared against the head of the queue
  always @(negedge clk) begin
    if (rst_n && (mem_rd_en || mem_wr_en)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {mem_addr, 8'h0, 5'h0, reg_idx}, 32'hFFFF_FFFF);
      end else begin
        chk("beat_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        chk("beat_idx", 32'(reg_idx), 32'(exp_q[0].idx));
        chk("beat_wr", {30'h0, mem_wr_en, mem_rd_en}, exp_q[0].wr ? 32'h2 : 32'h1);
        chk("beat_rf_wr", 32'(rf_wr_en), 32'(mem_rd_en & mem_ready));
        if (mem_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_seq(input logic [15:0] base, input logic [6:0] mask, input bit all, input bit wr);
    logic [15:0] a;
    int l = 0;
    beat_t b;
    for (int k = 0; k < 7; k++) begin
      if (all || mask[6-k]) begin
        a = base + 16'(all ? k : l);
        b.addr = a; b.idx = 3'(k); b.wr = wr;
        exp_q.push_back(b);
        l++;
      end
    end
  endtask

  // returns at start edge + 1 with garbage on the inputs to prove they are latched
  task automatic do_start(input logic [3:0] op, input logic [6:0] mask, input logic [15:0] base);
    @(posedge clk); #1;
    start_valid = 1'b1; opcode = op; imm_mask = mask; base_addr = base;
    @(negedge clk);
    chk("start_stall", 32'(stall_o), 32'h1);
    chk("start_not_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    start_valid = 1'b0; opcode = 4'b0000; imm_mask = ~mask; base_addr = 16'hDEAD;
  endtask

  task automatic wait_done(input int lat);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk("done_latency", seen ? 32'(n) : 32'hFFFF, 32'(lat));
    if (seen) begin
      chk("fin_stall_low", 32'(stall_o), 32'h0);
      chk("fin_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk("idle_after_fin", {30'h0, busy, done}, 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; opcode = '0; imm_mask = '0; base_addr = '0; mem_ready = 1'b1;
    #23;
    chk("rst_outputs", {mem_addr, 5'h0, reg_idx, mem_rd_en, mem_wr_en, rf_wr_en, stall_o, busy, done}, 32'h0);
    #4 rst_n = 1'b1;

    // LA base 0x0100, ready high
    push_seq(16'h0100, 7'h00, 1, 0);
    do_start(4'b1110, 7'h00, 16'h0100);
    wait_done(8);

    // non-multi opcode is ignored
    @(posedge clk); #1; start_valid = 1'b1; opcode = 4'b0111;
    @(negedge clk); chk("ignored_op_stall", 32'(stall_o), 32'h0);
    @(posedge clk); #1; start_valid = 1'b0;
    @(negedge clk); chk("ignored_op_busy", 32'(busy), 32'h0);

    // SM mask 1010101 base 0x0040
    push_seq(16'h0040, 7'b1010101, 0, 1);
    do_start(4'b1101, 7'b1010101, 16'h0040);
`ifdef SEQ_ZERO_SKIP_EN
    wait_done(5);
`else
    wait_done(8);
`endif

    // LM with empty mask: straight to FIN
    do_start(4'b1100, 7'b0000000, 16'h1234);
    wait_done(1);

    // LM sparse mask 0010011 -> regs 2,5,6
    push_seq(16'h0500, 7'b0010011, 0, 0);
    do_start(4'b1100, 7'b0010011, 16'h0500);
`ifdef SEQ_ZERO_SKIP_EN
    wait_done(4);
`else
    wait_done(8);
`endif

    // LA with mem_ready low for 3 cycles at k=2
    push_seq(16'h0200, 7'h00, 1, 0);
    do_start(4'b1110, 7'h00, 16'h0200);
    fork
      wait_done(11);
      begin
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
    join

    // SA wrapping past 0xFFFF
    push_seq(16'hFFFD, 7'h00, 1, 1);
    do_start(4'b1111, 7'h00, 16'hFFFD);
    wait_done(8);

    // LM interrupted by reset at k=3
    push_seq(16'h0600, 7'b1111111, 0, 0);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    do_start(4'b1100, 7'b1111111, 16'h0600);
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("held_before_reset", 32'(mem_rd_en), 32'h1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", {mem_addr, 5'h0, reg_idx, mem_rd_en, mem_wr_en, rf_wr_en, stall_o, busy, done}, 32'h0);
    chk("reset_mid_pending", 32'(exp_q.size()), 32'h1);
    exp_q.delete();
    mem_ready = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {30'h0, busy, done}, 32'h0);

    // fresh LA after reset starts from k=0 with its own base
    push_seq(16'h0300, 7'h00, 1, 0);
    do_start(4'b1110, 7'h00, 16'h0300);
    wait_done(8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
